// File: rtl/mux_sel_pipe_if.sv
// Handshake/data bundle for mux_sel_pipe: input request side and output queue side.
// Y_PAR is present only when MUX_SEL_PIPE_PARITY_EN is defined.
interface mux_sel_pipe_if #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned WIN  = 4,
    parameter int unsigned WY   = 5,
    parameter int unsigned SELW = 2
);
    logic [NCH*WIN-1:0] d;
    logic [SELW-1:0]    s;
    logic               sx;
    logic               in_valid;
    logic               in_ready;
    logic [WY-1:0]      y;
    logic               out_valid;
    logic               out_ready;
    logic               sel_err;
`ifdef MUX_SEL_PIPE_PARITY_EN
    logic               y_par;
`endif

    // Producer/consumer environment side.
    modport master (
        output d,
        output s,
        output sx,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  y,
        input  out_valid,
`ifdef MUX_SEL_PIPE_PARITY_EN
        input  y_par,
`endif
        input  sel_err
    );

    // Selector side.
    modport slave (
        input  d,
        input  s,
        input  sx,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output y,
        output out_valid,
`ifdef MUX_SEL_PIPE_PARITY_EN
        output y_par,
`endif
        output sel_err
    );
endinterface

// File: rtl/mux_sel_pipe.sv
// Registered N-to-1 selector with zero/sign extension feeding a 2-entry output FIFO.
// Optional feature macro: MUX_SEL_PIPE_PARITY_EN (adds stored even parity on Y_PAR).
module mux_sel_pipe #(
    parameter int unsigned NCH  = 4,
    parameter int unsigned WIN  = 4,
    parameter int unsigned WY   = 5,
    parameter int unsigned SELW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_sel_pipe_if.slave    bus
);

    if (WIN > WY) begin : g_win_chk
        $error("mux_sel_pipe: WIN must not exceed WY");
    end
    if ((2 ** SELW) < NCH) begin : g_sel_chk
        $error("mux_sel_pipe: SELW too narrow for NCH");
    end
    if ((NCH < 2) || (NCH > 16) || (WIN < 1)) begin : g_rng_chk
        $error("mux_sel_pipe: NCH or WIN out of range");
    end

    logic [1:0][WY-1:0] mem_q, mem_d;
    logic [WY-1:0]      last_q, last_d;
    logic [1:0]         count_q, count_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               sel_err_q, sel_err_d;

    logic [WIN-1:0]     ch;
    logic [WY-1:0]      ext;
    logic               sel_bad;
    logic               push;
    logic               pop;

    always_comb begin
        ch      = '0;
        sel_bad = (int'(bus.s) >= int'(NCH));
        for (int k = 0; k < int'(NCH); k++) begin
            if (int'(bus.s) == k) begin
                ch = bus.d[k*WIN +: WIN];
            end
        end
    end

    // Upper bits replicate the channel MSB only for signed operands; empty loop when WIN == WY.
    always_comb begin
        ext          = '0;
        ext[WIN-1:0] = ch;
        for (int i = int'(WIN); i < int'(WY); i++) begin
            ext[i] = bus.sx & ch[WIN-1];
        end
        if (sel_bad) begin
            ext = '0;
        end
    end

    assign push = bus.in_valid & in_ready_q;
    assign pop  = out_valid_q & bus.out_ready;

    always_comb begin
        mem_d     = mem_q;
        last_d    = last_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        sel_err_d = sel_err_q | (push & sel_bad);

        if (push) begin
            mem_d[wr_ptr_q] = ext;
        end
        if (pop) begin
            last_d = mem_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Handshake flags are registered from the next count, so IN_READY never sees OUT_READY.
        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '0;
            last_q      <= '0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            last_q      <= last_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.y         = out_valid_q ? mem_q[rd_ptr_q] : last_q;

`ifdef MUX_SEL_PIPE_PARITY_EN
    logic [1:0] par_q, par_d;
    logic       last_par_q, last_par_d;

    always_comb begin
        par_d      = par_q;
        last_par_d = last_par_q;
        if (push) begin
            par_d[wr_ptr_q] = ^ext;
        end
        if (pop) begin
            last_par_d = par_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q      <= 2'b00;
            last_par_q <= 1'b0;
        end else begin
            par_q      <= par_d;
            last_par_q <= last_par_d;
        end
    end

    assign bus.y_par = out_valid_q ? par_q[rd_ptr_q] : last_par_q;
`endif

endmodule
